// File: rtl/i2c_sniffer.sv
// Passive I2C bus monitor. It samples SCL/SDA only and never drives them.
// Decoded bus events become 10-bit records {kind[1:0], byte[7:0]}, which are
// queued in a show-ahead FIFO for the host to pop.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no transfer in progress; SCL edges ignored until a START
//   BITS  | collecting the 8 data bits of a byte, MSB first
//   ACK   | byte complete; the next SCL rise samples ACK/NACK
module i2c_sniffer #(
    parameter int FILT = 3,
    parameter int AW   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scl_i,
    input  logic        sda_i,
    input  logic        rd_en,
    input  logic        ovf_clr,
    output logic [9:0]  rd_data,
    output logic        rd_valid,
    output logic [AW:0] level,
    output logic        overflow,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, BITS, ACK} state_t;

    localparam int         SCL     = 0;
    localparam int         SDA     = 1;
    localparam int         DEPTH   = 1 << AW;
    localparam logic [3:0] FILT_TC = 4'(FILT - 1);
    localparam logic [1:0] KIND_START = 2'b10;
    localparam logic [1:0] KIND_STOP  = 2'b11;

    logic [1:0]      scl_sync, sda_sync;
    logic [1:0]      line_s, filt, filt_q;
    logic [1:0][3:0] filt_cnt;
    logic            scl_rise, scl_hi, start_det, stop_det;

    state_t          state, state_nx;
    logic [2:0]      bit_cnt, bit_cnt_nx;
    logic [7:0]      shreg, shreg_nx;
    logic            push;
    logic [9:0]      push_rec;

    logic [9:0]      mem [DEPTH];
    logic [AW:0]     wptr, rptr;
    logic            full, empty, do_push, do_pop, drop;

    // Two-stage synchronizers; idle bus level is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= 2'b11;
            sda_sync <= 2'b11;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
        end
    end

    assign line_s = {sda_sync[1], scl_sync[1]};

    // Glitch filter: a line flips only after FILT consecutive differing samples;
    // the down-counter reloads whenever the synced value agrees again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt     <= 2'b11;
            filt_cnt <= {FILT_TC, FILT_TC};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (line_s[i] == filt[i]) begin
                    filt_cnt[i] <= FILT_TC;
                end else if (filt_cnt[i] == 4'd0) begin
                    filt[i]     <= line_s[i];
                    filt_cnt[i] <= FILT_TC;
                end else begin
                    filt_cnt[i] <= filt_cnt[i] - 4'd1;
                end
            end
        end
    end

    // Previous-cycle filtered levels for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) filt_q <= 2'b11;
        else        filt_q <= filt;
    end

    // An SCL rise implies SCL was low last cycle, so a simultaneous SDA edge
    // can never qualify as START/STOP and is treated as a data sample only.
    assign scl_rise  = filt[SCL] & ~filt_q[SCL];
    assign scl_hi    = filt[SCL] &  filt_q[SCL];
    assign start_det = scl_hi & ~filt[SDA] &  filt_q[SDA];
    assign stop_det  = scl_hi &  filt[SDA] & ~filt_q[SDA];

    // Decoder state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shreg   <= shreg_nx;
        end
    end

    // Decoder next-state and record generation; STOP/START override data.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shreg_nx   = shreg;
        push       = 1'b0;
        push_rec   = 10'h000;
        if (stop_det) begin
            push     = 1'b1;
            push_rec = {KIND_STOP, 8'h00};
            state_nx = IDLE;
        end else if (start_det) begin
            push       = 1'b1;
            push_rec   = {KIND_START, 8'h00};
            state_nx   = BITS;
            bit_cnt_nx = 3'd0;
            shreg_nx   = 8'h00;
        end else if (scl_rise) begin
            case (state)
                BITS: begin
                    shreg_nx   = {shreg[6:0], filt[SDA]};
                    bit_cnt_nx = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_nx = ACK;
                end
                ACK: begin
                    push       = 1'b1;
                    push_rec   = {1'b0, filt[SDA], shreg};
                    state_nx   = BITS;
                    bit_cnt_nx = 3'd0;
                end
                default: begin
                end
            endcase
        end
    end

    assign empty   = (wptr == rptr);
    assign full    = (wptr == {~rptr[AW], rptr[AW-1:0]});
    assign do_pop  = rd_en & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    // Record storage; a full-FIFO push paired with a pop reuses the popped slot.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= push_rec;
    end

    // FIFO pointers and sticky overflow; a drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            if (drop)         overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    assign rd_data  = empty ? 10'h000 : mem[rptr[AW-1:0]];
    assign rd_valid = ~empty;
    assign level    = wptr - rptr;
    assign busy     = (state != IDLE);
endmodule

// File: tb/tb_i2c_sniffer.sv
// Bench for i2c_sniffer: drives bus transactions with random bytes, timing and
// sub-filter glitches, and checks popped records against an expected-record
// queue built from the transaction content (bounded to the FIFO depth).
module tb_i2c_sniffer;
    localparam int FILT  = 3;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst_n;
    logic        scl_i;
    logic        sda_i;
    logic        rd_en;
    logic        ovf_clr;
    logic [9:0]  rd_data;
    logic        rd_valid;
    logic [AW:0] level;
    logic        overflow;
    logic        busy;

    logic        auto_rd;
    logic        man_rd;
    logic        pop_on;
    int          glitch_pct;
    int          n_chk;
    int          n_err;
    logic [9:0]  exp_q[$];
    logic        exp_ovf;

    assign rd_en = auto_rd | man_rd;

    i2c_sniffer #(.FILT(FILT), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .rd_en    (rd_en),
        .ovf_clr  (ovf_clr),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .overflow (overflow),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int hp();
        return $urandom_range(FILT + 4, FILT + 10);
    endfunction

    function automatic int gl();
        return $urandom_range(1, FILT - 1);
    endfunction

    // Expected FIFO contents: records beyond the depth are lost and flag overflow.
    task automatic model_push(input logic [9:0] rec);
        if (exp_q.size() < DEPTH) exp_q.push_back(rec);
        else exp_ovf = 1'b1;
    endtask

    // One SCL clock pulse carrying bit b, with optional short glitches on both lines.
    task automatic bit_clk(input logic b);
        sda_i = b;
        cyc(hp());
        scl_i = 1'b1;
        cyc(hp());
        if ($urandom_range(0, 99) < glitch_pct) begin
            sda_i = ~b;
            cyc(gl());
            sda_i = b;
            cyc(hp());
        end
        scl_i = 1'b0;
        cyc(hp());
        if ($urandom_range(0, 99) < glitch_pct) begin
            scl_i = 1'b1;
            cyc(gl());
            scl_i = 1'b0;
            cyc(hp());
        end
    endtask

    task automatic do_start();
        model_push(10'h200);
        sda_i = 1'b1;
        cyc(hp());
        scl_i = 1'b1;
        cyc(hp());
        sda_i = 1'b0;
        cyc(hp());
        scl_i = 1'b0;
        cyc(hp());
    endtask

    task automatic do_stop();
        model_push(10'h300);
        sda_i = 1'b0;
        cyc(hp());
        scl_i = 1'b1;
        cyc(hp());
        sda_i = 1'b1;
        cyc(hp());
    endtask

    task automatic send_byte(input logic [7:0] d, input logic nack);
        for (int i = 7; i >= 0; i--) bit_clk(d[i]);
        model_push({1'b0, nack, d});
        bit_clk(nack);
    endtask

    task automatic partial(input int n);
        for (int i = 0; i < n; i++) bit_clk(1'($urandom_range(0, 1)));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        cyc(4);
        chk("drain_left", exp_q.size(), 0);
        chk("drain_level", level, 0);
        chk("drain_valid", rd_valid, 0);
        chk("drain_busy", busy, 0);
    endtask

    // Background reader: pops at random cycles and compares the head record.
    initial begin
        auto_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (pop_on && rd_valid && $urandom_range(0, 3) != 0) begin
                if (exp_q.size() == 0) chk("extra_rec", rd_valid, 0);
                else chk("rec", rd_data, exp_q.pop_front());
                auto_rd = 1'b1;
            end else begin
                auto_rd = 1'b0;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog timeout checks=%0d", n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        exp_ovf = 1'b0;
        rst_n = 1'b0;
        scl_i = 1'b1;
        sda_i = 1'b1;
        man_rd = 1'b0;
        ovf_clr = 1'b0;
        pop_on = 1'b0;
        glitch_pct = 30;
        cyc(3);
        chk("rst_level", level, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_data", rd_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        cyc(3);
        pop_on = 1'b1;

        // Write transaction with glitches on every bit.
        glitch_pct = 100;
        do_start();
        send_byte(8'hD0, 1'b0);
        send_byte(8'h07, 1'b0);
        do_stop();
        drain();
        glitch_pct = 30;

        // Read with NACK.
        do_start();
        send_byte(8'hD1, 1'b0);
        send_byte(8'h5A, 1'b1);
        do_stop();
        drain();

        // Repeated START after a partial byte.
        do_start();
        send_byte(8'hD0, 1'b0);
        partial(3);
        do_start();
        send_byte(8'hD1, 1'b0);
        do_stop();
        drain();

        // Short SDA low pulse with SCL high on an idle bus.
        sda_i = 1'b0;
        cyc(FILT - 1);
        sda_i = 1'b1;
        cyc(20);
        chk("glitch_level", level, 0);
        chk("glitch_busy", busy, 0);

        // Overflow: fill without popping.
        pop_on = 1'b0;
        cyc(2);
        do_start();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        do_stop();
        cyc(12);
        chk("ovf_level", level, exp_q.size());
        chk("ovf_flag", overflow, exp_ovf);
        chk("ovf_busy", busy, 0);
        chk("ovf_head", rd_data, exp_q[0]);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        chk("ovf_cleared", overflow, 0);

        // START pushed in the same cycle as a pop while full.
        cyc(1);
        sda_i = 1'b0;
        chk("full_head", rd_data, exp_q.pop_front());
        model_push(10'h200);
        cyc(2 + FILT);
        man_rd = 1'b1;
        cyc(1);
        man_rd = 1'b0;
        @(negedge clk);
        chk("pushpop_level", level, exp_q.size());
        chk("pushpop_ovf", overflow, exp_ovf);
        chk("pushpop_head", rd_data, exp_q[0]);
        chk("pushpop_busy", busy, 1);

        // STOP dropped in the same cycle as ovf_clr.
        cyc(1);
        sda_i = 1'b1;
        model_push(10'h300);
        cyc(2 + FILT);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        @(negedge clk);
        chk("dropclr_ovf", overflow, exp_ovf);
        chk("dropclr_level", level, exp_q.size());
        chk("dropclr_busy", busy, 0);
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        @(negedge clk);
        chk("dropclr_cleared", overflow, 0);
        pop_on = 1'b1;
        drain();

        // Reset in the middle of a byte.
        pop_on = 1'b0;
        cyc(2);
        do_start();
        partial(4);
        chk("prerst_level", level, 1);
        chk("prerst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_ovf = 1'b0;
        chk("midrst_level", level, 0);
        chk("midrst_valid", rd_valid, 0);
        chk("midrst_data", rd_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ovf", overflow, 0);
        cyc(3);
        rst_n = 1'b1;
        cyc(2);
        pop_on = 1'b1;
        partial(5);
        chk("postrst_level", level, 0);
        chk("postrst_busy", busy, 0);
        do_stop();
        drain();

        // Randomized transactions.
        for (int t = 0; t < 6; t++) begin
            int nb;
            nb = $urandom_range(1, 3);
            do_start();
            for (int i = 0; i < nb; i++) send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                partial($urandom_range(1, 7));
                do_start();
                send_byte(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
            end
            do_stop();
            drain();
        end

        chk("final_ovf", overflow, exp_ovf);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
